mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the IF stage (fetch)
//  and the MEM stage (lw/sw) of the 5-stage MIPS pipeline. Serialises accesses,
//  tracks fixed memory latency with a counter, returns data with a one-cycle
//  ready pulse, and drives the stall lines that freeze PC/IFID (fetch wait) or
//  the whole pipe (data wait). Sits beside the load-use stall unit; stalls are OR-ed.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  MEM_LAT  2   cycles from mem_en issue to mem_rdata valid; legal 1..15
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  if_req     in   1       fetch request; held with if_addr until if_ready
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  DATA_W  fetched instruction, valid while if_ready=1
//  if_ready   out  1       one-cycle completion pulse for fetch
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_ready
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid while d_ready=1
//  d_ready    out  1       one-cycle completion pulse for data
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address, valid while mem_en=1
//  mem_wdata  out  DATA_W  memory write data, valid while mem_en=1
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  stall_if   out  1       freeze PC and IF/ID register
//  stall_mem  out  1       freeze the whole pipeline (PC through MEM/WB)
// BEHAVIOUR
//  - FSM: IDLE, BUSY_I, BUSY_D. 4-bit latency counter lat_cnt; 1-bit last_grant (0=I, 1=D).
//  - Issue (in IDLE, or in the completion cycle): pick among eligible requests.
//    Both pending: grant the one not in last_grant. Only one pending: grant it.
//    The requester completing this cycle is ineligible, so its old request is never reissued.
//  - Issue cycle T: mem_en=1, mem_we = d_we for D and 0 for I, mem_addr/mem_wdata from
//    the granted port. Go to BUSY_x, lat_cnt=MEM_LAT, update last_grant.
//  - BUSY_x: lat_cnt decrements each cycle. At lat_cnt==1, register mem_rdata into
//    x_rdata and set x_ready for cycle T+MEM_LAT+1.
//  - Throughput: one access per MEM_LAT+1 cycles. A new issue may coincide with a ready pulse.
//  - Store: completes identically with d_ready pulse; d_rdata holds its previous value.
//  - Requester drops req mid-access (flush): access still completes, ready still pulses
//    (requester ignores it), memory write is not cancelled.
//  - stall_mem = d_req & ~d_ready (combinational).
//  - stall_if = (if_req & ~if_ready) | stall_mem (combinational).
//  - x_rdata holds its value between accesses. mem_en=0 whenever nothing is issued.
//  - Reset (async, any time incl. mid-access): FSM=IDLE, lat_cnt=0, last_grant=1,
//    if_ready=d_ready=0, if_rdata=d_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0.
//    An in-flight memory response is discarded. First grant after reset with both pending is I.
// TESTING (MEM_LAT=2 unless stated)
//  1 if_req=1 addr 0x40 alone, mem_rdata=0x8C010004 at T+2 -> mem_en only at T,
//    if_rdata=0x8C010004 and if_ready=1 at T+3, stall_if=1 from T to T+2.
//  2 d_req load 0x100 and if_req together after reset -> I issued at T, D at T+3,
//    I at T+6 (alternation); stall_mem=1 until d_ready at T+6.
//  3 store d_addr 0x200 d_wdata 0xDEADBEEF -> mem_en=mem_we=1 at T with those values,
//    d_ready at T+3, d_rdata unchanged.
//  4 if_req held continuously -> mem_en at T, T+3, T+6; if_ready at T+3, T+6; no double issue.
//  5 rst_n low at T+1 of a load -> all outputs 0 asynchronously; no d_ready afterwards;
//    a new request after release issues cleanly.
//  6 MEM_LAT=1 and MEM_LAT=15 -> ready exactly MEM_LAT+1 cycles after mem_en.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the fetch (IF)
//   and data (MEM) stages. One access is in flight at a time; a fixed memory
//   latency is tracked with a down-counter and each completion is signalled
//   by a one-cycle ready pulse together with registered read data.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr          fetch request, held until if_ready
//   if_rdata/if_ready       fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (load/store), held until d_ready
//   d_rdata/d_ready         load data and its one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, driven in the issue cycle
//   mem_rdata               memory read data, valid MEM_LAT cycles after mem_en
//   stall_if                freeze PC and IF/ID
//   stall_mem               freeze the whole pipeline
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic       last_grant;   // 0 = fetch won last, 1 = data won last
    logic       busy_store;   // access in flight is a store: keep d_rdata

    logic i_elig;
    logic d_elig;
    logic issue;
    logic grant_d;

    // A port pulsing ready this cycle still shows its old request; masking it
    // prevents that completed request from being issued a second time.
    // The FSM returns to IDLE in the completion cycle, so issuing only from
    // IDLE lets a new access overlap the ready pulse.
    always_comb begin
        i_elig  = if_req & ~if_ready;
        d_elig  = d_req & ~d_ready;
        issue   = rst_n & (state == IDLE) & (i_elig | d_elig);
        grant_d = (i_elig & d_elig) ? ~last_grant : d_elig;

        mem_en    = issue;
        mem_we    = issue & grant_d & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_addr = grant_d ? d_addr : if_addr;
            if (grant_d) begin
                mem_wdata = d_wdata;
            end
        end

        stall_mem = d_req & ~d_ready;
        stall_if  = (if_req & ~if_ready) | stall_mem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            busy_store <= 1'b0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state      <= grant_d ? BUSY_D : BUSY_I;
                        lat_cnt    <= LAT_INIT;
                        last_grant <= grant_d;
                        busy_store <= grant_d & d_we;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // lat_cnt==1 marks the cycle in which mem_rdata is valid.
                    if (lat_cnt == 4'd1) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                        if (state == BUSY_I) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            d_ready <= 1'b1;
                            if (!busy_store) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Latency-extreme instances: index 0 -> MEM_LAT=1, index 1 -> MEM_LAT=15
    logic        s_req   [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_rdata [2];
    logic        s_rdy   [2];
    logic [31:0] s_drdata[2];
    logic        s_drdy  [2];
    logic        s_en    [2];
    logic        s_we    [2];
    logic [31:0] s_maddr [2];
    logic [31:0] s_mwdata[2];
    logic [31:0] s_mrdata[2];
    logic        s_stif  [2];
    logic        s_stmem [2];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(s_req[0]), .if_addr(s_addr[0]), .if_rdata(s_rdata[0]), .if_ready(s_rdy[0]),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(s_drdata[0]), .d_ready(s_drdy[0]),
        .mem_en(s_en[0]), .mem_we(s_we[0]), .mem_addr(s_maddr[0]), .mem_wdata(s_mwdata[0]),
        .mem_rdata(s_mrdata[0]), .stall_if(s_stif[0]), .stall_mem(s_stmem[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_lat15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(s_req[1]), .if_addr(s_addr[1]), .if_rdata(s_rdata[1]), .if_ready(s_rdy[1]),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(s_drdata[1]), .d_ready(s_drdy[1]),
        .mem_en(s_en[1]), .mem_we(s_we[1]), .mem_addr(s_maddr[1]), .mem_wdata(s_mwdata[1]),
        .mem_rdata(s_mrdata[1]), .stall_if(s_stif[1]), .stall_mem(s_stmem[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory contents: fixed function of the address
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h8C01, ~a[15:0]};
    endfunction

    // Reference model: an access issued at cycle c owns the memory until
    // cycle c+LAT+1, when its ready pulse appears.
    typedef struct {
        int          due;
        bit          port_d;
        bit          st;
        logic [31:0] data;
    } cpl_t;

    cpl_t        pend[$];
    int          cyc;
    int          free_at;
    bit          last_d;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    bit          saw_ir;
    bit          saw_dr;
    logic [31:0] rsp[int];

    task automatic model_reset();
        pend.delete();
        rsp.delete();
        free_at = 0;
        last_d  = 1'b1;
        exp_ird = '0;
        exp_drd = '0;
        saw_ir  = 1'b0;
        saw_dr  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_if_ready"}, {31'b0, if_ready}, 32'd0);
        check({tag, "_d_ready"}, {31'b0, d_ready}, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_stall_if"}, {31'b0, stall_if}, 32'd0);
        check({tag, "_stall_mem"}, {31'b0, stall_mem}, 32'd0);
    endtask

    initial begin
        bit          want_rst;
        bit          e_ir, e_dr, ie, de, iss, gd;
        logic [31:0] e_addr, e_wdata;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            s_req[k] = 1'b0; s_addr[k] = '0; s_mrdata[k] = '0;
        end
        model_reset();
        cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        want_rst = 1'b0;
        for (int it = 0; it < 2000; it++) begin
            @(posedge clk);
            cyc++;
            #1;
            // Requesters: hold until ready, occasionally flush mid-access
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req  = 1'b1;
                    if_addr = 32'($urandom_range(0, 255)) << 2;
                end
            end else if (saw_ir) begin
                if ($urandom_range(0, 1) == 1) if_req = 1'b0;
                else if_addr = 32'($urandom_range(0, 255)) << 2;
            end else if ($urandom_range(0, 39) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req || saw_dr) begin
                if (d_req && $urandom_range(0, 1) == 1) d_req = 1'b0;
                else if ($urandom_range(0, 2) == 0 || d_req) begin
                    d_req   = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = 32'($urandom_range(0, 255)) << 2;
                    d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                d_req = 1'b0;
            end
            mem_rdata = rsp.exists(cyc) ? rsp[cyc] : $urandom;
            if (rsp.exists(cyc)) rsp.delete(cyc);

            if (it == 700 || it == 1400) want_rst = 1'b1;
            if (want_rst && pend.size() > 0) begin
                // Asynchronous reset in the middle of an access
                want_rst = 1'b0;
                #1;
                rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
                #1;
                check_all_zero("async_rst");
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                continue;
            end

            @(negedge clk);
            e_ir = 1'b0; e_dr = 1'b0;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].port_d) begin
                        e_dr = 1'b1;
                        if (!pend[i].st) exp_drd = pend[i].data;
                    end else begin
                        e_ir = 1'b1;
                        exp_ird = pend[i].data;
                    end
                    pend.delete(i);
                end
            end
            ie  = if_req && !e_ir;
            de  = d_req && !e_dr;
            iss = (cyc >= free_at) && (ie || de);
            gd  = (ie && de) ? !last_d : de;
            e_addr  = iss ? (gd ? d_addr : if_addr) : 32'd0;
            e_wdata = (iss && gd) ? d_wdata : 32'd0;

            check("mem_en", {31'b0, mem_en}, {31'b0, iss});
            check("mem_we", {31'b0, mem_we}, {31'b0, iss && gd && d_we});
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("if_ready", {31'b0, if_ready}, {31'b0, e_ir});
            check("d_ready", {31'b0, d_ready}, {31'b0, e_dr});
            check("if_rdata", if_rdata, exp_ird);
            check("d_rdata", d_rdata, exp_drd);
            check("stall_mem", {31'b0, stall_mem}, {31'b0, de});
            check("stall_if", {31'b0, stall_if}, {31'b0, ie || de});

            if (iss) begin
                cpl_t c;
                free_at  = cyc + LAT + 1;
                last_d   = gd;
                c.due    = cyc + LAT + 1;
                c.port_d = gd;
                c.st     = gd && d_we;
                c.data   = mem_val(e_addr);
                pend.push_back(c);
            end
            // Memory responder driven from what the DUT actually issued
            if (mem_en && !mem_we) rsp[cyc + LAT] = mem_val(mem_addr);
            saw_ir = if_ready;
            saw_dr = d_ready;
        end

        // Latency extremes: single fetch, ready exactly MEM_LAT+1 after mem_en
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int          lat;
            int          n_en;
            int          t_en;
            int          t_rdy;
            logic [31:0] got;
            lat   = (k == 0) ? 1 : 15;
            n_en  = 0;
            t_en  = -1;
            t_rdy = -1;
            got   = '0;
            @(posedge clk);
            #1;
            s_addr[k]   = 32'h40 + 32'(k * 4);
            s_mrdata[k] = mem_val(s_addr[k]);
            s_req[k]    = 1'b1;
            for (int n = 0; n < 40 && t_rdy < 0; n++) begin
                @(negedge clk);
                if (s_en[k]) begin
                    n_en++;
                    if (t_en < 0) begin
                        t_en = n;
                        check("lat_x_mem_addr", s_maddr[k], s_addr[k]);
                        check("lat_x_mem_we", {31'b0, s_we[k]}, 32'd0);
                        check("lat_x_mem_wdata", s_mwdata[k], 32'd0);
                    end
                end
                if (s_rdy[k]) begin
                    t_rdy = n;
                    got   = s_rdata[k];
                end else begin
                    check("lat_x_stall_if", {31'b0, s_stif[k]}, 32'd1);
                end
                check("lat_x_d_ready", {31'b0, s_drdy[k]}, 32'd0);
                @(posedge clk);
                #1;
                if (t_rdy >= 0) s_req[k] = 1'b0;
            end
            check("lat_x_issue_cycle", 32'(t_en), 32'd0);
            check("lat_x_ready_gap", 32'(t_rdy - t_en), 32'(lat + 1));
            check("lat_x_single_issue", 32'(n_en), 32'd1);
            check("lat_x_if_rdata", got, mem_val(s_addr[k]));
            @(negedge clk);
            check("lat_x_stall_mem", {31'b0, s_stmem[k]}, 32'd0);
            check("lat_x_d_rdata", s_drdata[k], 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
